// File: rtl/alu_trunc_issue.sv
// Registered operand-issue FIFO feeding the ALU32 truncation unit; pre-decodes B mode/cut-count.
// Optional activity counters (stat_issued, stat_stall) are built when ISSUE_STATS_EN is defined.
module alu_trunc_issue #(
    parameter int DEPTH = 2,
    parameter int OP_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_a,
    input  logic [31:0]     in_b,
    input  logic [OP_W-1:0] in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_a,
    output logic [31:0]     out_b,
    output logic [OP_W-1:0] out_op,
    output logic            out_mode,
    output logic            out_zero_cnt
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]     stat_issued,
    output logic [31:0]     stat_stall
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]     a;
        logic [31:0]     b;
        logic [OP_W-1:0] op;
        logic            mode;
        logic            zero_cnt;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic               push;
    logic               pop;
    logic [PTR_W-1:0]   rd_next;
    logic [CNT_W-1:0]   count_next;
    entry_t             entry_in;
    entry_t             head_next;
    logic               head_load;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != {CNT_W{1'b0}});
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state decode: pointer/count update and the entry that becomes the head after this edge.
    always_comb begin
        entry_in.a        = in_a;
        entry_in.b        = in_b;
        entry_in.op       = in_op;
        entry_in.mode     = in_b[31];
        entry_in.zero_cnt = (in_b[4:0] == 5'd0);

        if (pop) begin
            rd_next = rd_ptr + PTR_W'(1'b1);
        end else begin
            rd_next = rd_ptr;
        end

        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1'b1);
            2'b01:   count_next = count - CNT_W'(1'b1);
            default: count_next = count;
        endcase

        // The slot being written this cycle is the new head only when the queue drains to it.
        if (push && (wr_ptr == rd_next)) begin
            head_next = entry_in;
        end else begin
            head_next = mem[rd_next];
        end

        head_load = (count_next != {CNT_W{1'b0}});
    end

    // FIFO storage, pointers, count and registered head outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= {PTR_W{1'b0}};
            wr_ptr       <= {PTR_W{1'b0}};
            count        <= {CNT_W{1'b0}};
            out_a        <= 32'd0;
            out_b        <= 32'd0;
            out_op       <= {OP_W{1'b0}};
            out_mode     <= 1'b0;
            out_zero_cnt <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry_in;
                wr_ptr      <= wr_ptr + PTR_W'(1'b1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            if (head_load) begin
                out_a        <= head_next.a;
                out_b        <= head_next.b;
                out_op       <= head_next.op;
                out_mode     <= head_next.mode;
                out_zero_cnt <= head_next.zero_cnt;
            end
        end
    end

`ifdef ISSUE_STATS_EN
    // Issue and back-pressure counters; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued <= 32'd0;
            stat_stall  <= 32'd0;
        end else begin
            if (pop) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (out_valid && !out_ready) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_trunc_issue.sv
// Directed + light random bench for alu_trunc_issue with a queue scoreboard of expected head entries.
module tb_alu_trunc_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_op;
    logic        out_mode;
    logic        out_zero_cnt;
`ifdef ISSUE_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_stall;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
    } req_t;

    req_t q[$];
    bit   exp_zero_outs;
    int   m_issued;
    int   m_stall;

    always #5 clk = ~clk;

    alu_trunc_issue #(.DEPTH(2), .OP_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_a        (out_a),
        .out_b        (out_b),
        .out_op       (out_op),
        .out_mode     (out_mode),
        .out_zero_cnt (out_zero_cnt)
`ifdef ISSUE_STATS_EN
        ,
        .stat_issued  (stat_issued),
        .stat_stall   (stat_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model just before the edge, then advance the model across the edge.
    task automatic cyc();
        bit   m_ready;
        bit   m_valid;
        req_t h;
        m_ready = (q.size() != 2);
        m_valid = (q.size() != 0);
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            h = q[0];
            chk("out_a", out_a, h.a);
            chk("out_b", out_b, h.b);
            chk("out_op", {28'd0, out_op}, {28'd0, h.op});
            chk("out_mode", {31'd0, out_mode}, {31'd0, h.b[31]});
            chk("out_zero_cnt", {31'd0, out_zero_cnt}, {31'd0, (h.b[4:0] == 5'd0)});
        end else if (exp_zero_outs) begin
            chk("rst_out_a", out_a, 32'd0);
            chk("rst_out_b", out_b, 32'd0);
            chk("rst_out_misc", {26'd0, out_op, out_mode, out_zero_cnt}, 32'd0);
        end
`ifdef ISSUE_STATS_EN
        chk("stat_issued", stat_issued, m_issued);
        chk("stat_stall", stat_stall, m_stall);
`endif
        @(posedge clk);
        if (rst) begin
            q.delete();
            exp_zero_outs = 1'b1;
            m_issued = 0;
            m_stall  = 0;
        end else begin
            if (m_valid && out_ready) begin
                void'(q.pop_front());
                m_issued++;
            end
            if (m_valid && !out_ready) begin
                m_stall++;
            end
            if (in_valid && m_ready) begin
                q.push_back({in_a, in_b, in_op});
                exp_zero_outs = 1'b0;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    initial begin
        exp_zero_outs = 1'b0;
        m_issued = 0;
        m_stall  = 0;
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 32'h1234_5678, 32'h0000_0003, 4'd9);
        cyc();
        rst = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 4'd0);
        cyc();

        // T1: single request, one-cycle latency, popped immediately
        out_ready = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 32'h8000_0008, 4'd3);
        cyc();
        drive(1'b0, 32'd0, 32'd0, 4'd0);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_mode", {31'd0, out_mode}, 32'd1);
        cyc();
        cyc();

        // T2: fill with back-pressure; third request held by source
        out_ready = 1'b0;
        drive(1'b1, 32'h1, 32'h0000_0005, 4'd1);
        cyc();
        drive(1'b1, 32'h2, 32'h8000_0000, 4'd2);
        cyc();
        drive(1'b1, 32'h3, 32'h0000_0011, 4'd4);
        chk("t2_full", {31'd0, in_ready}, 32'd0);
        cyc();
        cyc();

        // T3: pop from full with in_valid high, then drain in order
        out_ready = 1'b1;
        cyc();
        cyc();
        drive(1'b0, 32'd0, 32'd0, 4'd0);
        cyc();
        cyc();

        // T4: cut count decode at the 0 / 31 boundary
        drive(1'b1, 32'hCAFE_0001, 32'h0000_0020, 4'd5);
        cyc();
        drive(1'b1, 32'hCAFE_0002, 32'h0000_001F, 4'd6);
        chk("t4_zero", {30'd0, out_zero_cnt, out_mode}, 32'd2);
        cyc();
        drive(1'b0, 32'd0, 32'd0, 4'd0);
        chk("t4_nonzero", {31'd0, out_zero_cnt}, 32'd0);
        cyc();

        // T5: reset with two entries queued, in_valid ignored in the reset cycle
        out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_0001, 32'h0000_0001, 4'd7);
        cyc();
        drive(1'b1, 32'hAAAA_0002, 32'h0000_0002, 4'd8);
        cyc();
        rst = 1'b1;
        drive(1'b1, 32'hBBBB_BBBB, 32'h0000_0004, 4'd1);
        cyc();
        rst = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 4'd0);
        cyc();
        out_ready = 1'b1;
        drive(1'b1, 32'h5555_AAAA, 32'h8000_0000, 4'd15);
        cyc();
        drive(1'b0, 32'd0, 32'd0, 4'd0);
        cyc();
        cyc();

        // Random traffic exercising pointer wrap and concurrent push/pop
        for (int i = 0; i < 60; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            cyc();
        end
        drive(1'b0, 32'd0, 32'd0, 4'd0);
        out_ready = 1'b1;
        cyc();
        cyc();
        cyc();

`ifdef ISSUE_STATS_EN
        // T6: stat counters clear on reset
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        chk("t6_issued_clr", stat_issued, 32'd0);
        chk("t6_stall_clr", stat_stall, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
